// File: rtl/ifetch_tcm.sv
// Instruction fetch stage driving a TCM word port, with a 2-entry skid FIFO toward decode.
// Optional stall counter output is enabled by defining IFETCH_STALL_CNT_EN.
module ifetch_tcm #(
  parameter int          MEM_ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  output logic [MEM_ADDR_WIDTH+1:2] o_inst_addr,
  input  logic [31:0]               i_inst,
  input  logic                      i_flush,
  input  logic [31:0]               i_flush_pc,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [31:0]               o_inst,
  output logic [31:0]               o_pc
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0]               o_stall_cnt
`endif
);

  logic [31:0] r_pc;
  logic        r_req_valid;
  logic [31:0] r_req_pc;
  logic [31:0] r_ent_pc   [2];
  logic [31:0] r_ent_inst [2];
  logic        r_head;
  logic [1:0]  r_count;

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_credit;
  logic        w_wr_idx;
  logic [31:0] w_flush_tgt;

  assign o_inst_addr = r_pc[MEM_ADDR_WIDTH+1:2];
  assign o_valid     = (r_count != 2'd0);
  assign o_inst      = r_ent_inst[r_head];
  assign o_pc        = r_ent_pc[r_head];

  // Occupancy the FIFO will have once the in-flight word lands; issue only if a slot remains.
  assign w_pop       = o_valid & i_ready;
  assign w_credit    = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_req_valid};
  assign w_issue     = ~i_flush & (w_credit < 3'd2);
  assign w_push      = r_req_valid & ~i_flush;
  assign w_wr_idx    = r_head ^ r_count[0];
  assign w_flush_tgt = i_flush_pc & ~32'd3;

  // Stage p0: program counter and fetch request tracking
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
    end else if (i_flush) begin
      r_pc        <= w_flush_tgt;
      r_req_valid <= 1'b0;
    end else begin
      r_req_valid <= w_issue;
      if (w_issue) r_pc <= r_pc + 32'd4;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_issue) r_req_pc <= r_pc;
  end

  // Stage p1: capture the returned word into the skid FIFO
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_ent_pc[i]   <= 32'd0;
        r_ent_inst[i] <= 32'd0;
      end
    end else if (i_flush) begin
      r_head  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_ent_pc[w_wr_idx]   <= r_req_pc;
        r_ent_inst[w_wr_idx] <= i_inst;
      end
      if (w_pop) r_head <= ~r_head;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!(w_push && !w_pop && r_count == 2'd2));
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                o_stall_cnt <= 32'd0;
    else if (o_valid & ~i_ready) o_stall_cnt <= o_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ifetch_tcm.sv
// Directed bench for ifetch_tcm with a registered-read TCM model.
// Covers reset timing, backpressure, flush cases, PC wrap and asynchronous reset.
module tb_ifetch_tcm;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:2]  inst_addr;
  logic [31:0] tcm_q;
  logic        flush;
  logic [31:0] flush_pc;
  logic        valid;
  logic        ready;
  logic [31:0] inst;
  logic [31:0] pc;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifetch_tcm #(.MEM_ADDR_WIDTH(8), .RESET_PC(32'h0)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .o_inst_addr (inst_addr),
    .i_inst      (tcm_q),
    .i_flush     (flush),
    .i_flush_pc  (flush_pc),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_inst      (inst),
    .o_pc        (pc)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

  // TCM contents: word k holds a tag plus k, so each word is distinguishable.
  function automatic logic [31:0] word(input logic [7:0] a);
    return {16'hC0DE, a, a ^ 8'h5A};
  endfunction

  always @(posedge clk) tcm_q <= word(inst_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; flush = 1'b0; flush_pc = 32'h0;
    @(posedge clk); #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_addr", {24'd0, inst_addr}, 32'h0);

    // Reset release: cycle 0 starts now
    rst = 1'b0;
    chk("c0_addr", {24'd0, inst_addr}, 32'h0);
    chk("c0_valid", {31'd0, valid}, 32'd0);
    step();
    chk("c1_valid", {31'd0, valid}, 32'd0);
    step();
    chk("c2_valid", {31'd0, valid}, 32'd1);
    chk("c2_pc", pc, 32'h0);
    chk("c2_inst", inst, word(8'd0));
    step();
    chk("c3_pc", pc, 32'h4);
    chk("c3_inst", inst, word(8'd1));
    step();
    chk("c4_pc", pc, 32'h8);
    chk("c4_inst", inst, word(8'd2));

    // Backpressure: i_ready low during cycles 2..6
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    ready = 1'b0;
    chk("bp_c2_pc", pc, 32'h0);
    for (int i = 3; i <= 6; i++) begin
      step();
      chk("bp_hold_valid", {31'd0, valid}, 32'd1);
      chk("bp_hold_pc", pc, 32'h0);
    end
    chk("bp_addr_held", {24'd0, inst_addr}, 32'h2);
    step();
    ready = 1'b1;
`ifdef IFETCH_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 32'd5);
`endif
    chk("bp_c7_pc", pc, 32'h0);
    step(); chk("bp_c8_pc", pc, 32'h4);
    step(); chk("bp_c9_pc", pc, 32'h8);
    step(); chk("bp_c10_pc", pc, 32'hC);
    chk("bp_c10_inst", inst, word(8'd3));

    // Flush to 0x40 while streaming
    flush = 1'b1; flush_pc = 32'h40;
    step(); flush = 1'b0;
    chk("fl_n1_valid", {31'd0, valid}, 32'd0);
    chk("fl_n1_addr", {24'd0, inst_addr}, 32'h10);
    step();
    chk("fl_n2_valid", {31'd0, valid}, 32'd0);
    step();
    chk("fl_n3_valid", {31'd0, valid}, 32'd1);
    chk("fl_n3_pc", pc, 32'h40);
    chk("fl_n3_inst", inst, word(8'd16));
    step();
    chk("fl_n4_pc", pc, 32'h44);

    // Fill the FIFO with i_ready low, then flush to unaligned 0x43
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold_pc", pc, 32'h44);
    end
    flush = 1'b1; flush_pc = 32'h43;
    step(); flush = 1'b0;
    chk("flf_n1_valid", {31'd0, valid}, 32'd0);
    chk("flf_n1_addr", {24'd0, inst_addr}, 32'h10);
    step();
    chk("flf_n2_valid", {31'd0, valid}, 32'd0);
    step();
    chk("flf_n3_valid", {31'd0, valid}, 32'd1);
    chk("flf_n3_pc", pc, 32'h40);
    chk("flf_n3_inst", inst, word(8'd16));
    step();
    chk("flf_stable_pc", pc, 32'h40);
    ready = 1'b1;
    step();
    chk("flf_next_pc", pc, 32'h44);

    // Back-to-back flushes: last target wins
    flush = 1'b1; flush_pc = 32'h10;
    step(); flush_pc = 32'h20;
    step(); flush = 1'b0;
    chk("b2b_addr", {24'd0, inst_addr}, 32'h8);
    chk("b2b_valid_a", {31'd0, valid}, 32'd0);
    step();
    chk("b2b_valid_b", {31'd0, valid}, 32'd0);
    step();
    chk("b2b_pc", pc, 32'h20);
    chk("b2b_inst", inst, word(8'd8));

    // PC wrap at 2**32 and TCM address aliasing
    flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
    step(); flush = 1'b0;
    chk("wrap_addr", {24'd0, inst_addr}, 32'hFF);
    step(); step();
    chk("wrap_pc0", pc, 32'hFFFF_FFFC);
    chk("wrap_inst0", inst, word(8'hFF));
    step();
    chk("wrap_pc1", pc, 32'h0);
    chk("wrap_inst1", inst, word(8'h00));
    flush = 1'b1; flush_pc = 32'h404;
    step(); flush = 1'b0;
    step(); step();
    chk("alias_pc", pc, 32'h404);
    chk("alias_inst", inst, word(8'h01));

    // Asynchronous reset pulse between edges
    step(); step();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_addr", {24'd0, inst_addr}, 32'h0);
    chk("arst_pc", pc, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("arst_c0_addr", {24'd0, inst_addr}, 32'h0);
    step();
    chk("arst_c1_valid", {31'd0, valid}, 32'd0);
    step();
    chk("arst_c2_valid", {31'd0, valid}, 32'd1);
    chk("arst_c2_pc", pc, 32'h0);
    chk("arst_c2_inst", inst, word(8'd0));
    step();
    chk("arst_c3_pc", pc, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
